// File: rtl/s32x_sdram_resp.sv
`default_nettype none
// ============================================================================
// s32x_sdram_resp : 32X SH2 SDRAM-bus responder with one-entry posted write buffer
// Revision: 1.0
// ============================================================================
module s32x_sdram_resp #(
    parameter int POST_WRITES = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] SDR_A,
    input  logic [15:0]       SDR_DI,
    output logic [15:0]       SDR_DO,
    input  logic              SDR_CS,
    input  logic [1:0]        SDR_WE,
    input  logic              SDR_RD,
    output logic              SDR_WAIT,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_DO,
    output logic [1:0]        MEM_BE,
    output logic              MEM_WE,
    output logic              MEM_REQ,
    input  logic [15:0]       MEM_DI,
    input  logic              MEM_ACK
);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DRAIN   = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;
    localparam logic [1:0] WR_WAIT = 2'd3;
    localparam logic       POSTED  = (POST_WRITES != 0);

    logic [1:0]        state;
    logic [1:0]        state_nxt;

    logic              served;
    logic [ADDR_W-1:0] srv_a;
    logic              srv_rd;
    logic [1:0]        srv_we;

    logic              buf_full;
    logic [ADDR_W-1:0] buf_addr;
    logic [15:0]       buf_data;
    logic [1:0]        buf_be;

    logic              acc;
    logic              same_acc;
    logic              new_acc;
    logic              new_rd;
    logic              new_wr;
    logic              issue_drain;
    logic              issue_rd;
    logic              issue_wr;
    logic              post_now;
    logic              drain_done;
    logic              rd_done;
    logic              wr_done;
    logic              done_now;

    // An access is "new" unless it is the very one already completed; any change
    // of address or strobes under a held CS counts as a fresh access.
    always_comb begin
        acc      = SDR_CS & (SDR_RD | (SDR_WE != 2'b00));
        same_acc = (SDR_A == srv_a) & (SDR_RD == srv_rd) & (SDR_WE == srv_we);
        new_acc  = acc & ~(served & same_acc);
        new_rd   = new_acc & SDR_RD;
        new_wr   = new_acc & ~SDR_RD;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue_drain || post_now) begin
                    state_nxt = DRAIN;
                end else if (issue_rd) begin
                    state_nxt = RD_WAIT;
                end else if (issue_wr) begin
                    state_nxt = WR_WAIT;
                end
            end
            DRAIN, RD_WAIT, WR_WAIT: begin
                if (MEM_ACK) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue_drain = 1'b0;
        issue_rd    = 1'b0;
        issue_wr    = 1'b0;
        post_now    = 1'b0;
        drain_done  = 1'b0;
        rd_done     = 1'b0;
        wr_done     = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full) begin
                    issue_drain = 1'b1;
                end else if (new_rd) begin
                    issue_rd = 1'b1;
                end else if (new_wr && POSTED) begin
                    post_now = 1'b1;
                end else if (new_wr) begin
                    issue_wr = 1'b1;
                end
            end
            DRAIN:   drain_done = MEM_ACK;
            RD_WAIT: rd_done    = MEM_ACK & new_rd;
            WR_WAIT: wr_done    = MEM_ACK & new_wr;
            default: ;
        endcase
        done_now = post_now | rd_done | wr_done;
        SDR_WAIT = RST_N & new_acc & ~done_now;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            served   <= 1'b0;
            srv_a    <= '0;
            srv_rd   <= 1'b0;
            srv_we   <= 2'b00;
            buf_full <= 1'b0;
            buf_addr <= '0;
            buf_data <= 16'h0000;
            buf_be   <= 2'b00;
            SDR_DO   <= 16'h0000;
            MEM_REQ  <= 1'b0;
            MEM_WE   <= 1'b0;
            MEM_BE   <= 2'b00;
            MEM_ADDR <= '0;
            MEM_DO   <= 16'h0000;
        end else begin
            if (done_now) begin
                served <= 1'b1;
                srv_a  <= SDR_A;
                srv_rd <= SDR_RD;
                srv_we <= SDR_WE;
            end else begin
                served <= served & acc & same_acc;
            end

            if (post_now) begin
                buf_full <= 1'b1;
                buf_addr <= SDR_A;
                buf_data <= SDR_DI;
                buf_be   <= SDR_WE;
            end else if (drain_done) begin
                buf_full <= 1'b0;
            end

            // Abandoned reads still finish on the bus but never reach SDR_DO.
            if (rd_done) begin
                SDR_DO <= MEM_DI;
            end

            if (issue_drain) begin
                MEM_REQ  <= 1'b1;
                MEM_WE   <= 1'b1;
                MEM_ADDR <= buf_addr;
                MEM_DO   <= buf_data;
                MEM_BE   <= buf_be;
            end else if (post_now || issue_wr) begin
                MEM_REQ  <= 1'b1;
                MEM_WE   <= 1'b1;
                MEM_ADDR <= SDR_A;
                MEM_DO   <= SDR_DI;
                MEM_BE   <= SDR_WE;
            end else if (issue_rd) begin
                MEM_REQ  <= 1'b1;
                MEM_WE   <= 1'b0;
                MEM_ADDR <= SDR_A;
                MEM_BE   <= 2'b11;
            end else if ((state != IDLE) && MEM_ACK) begin
                MEM_REQ <= 1'b0;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_s32x_sdram_resp.sv
`default_nettype none
// ============================================================================
// tb_s32x_sdram_resp : directed vector bench for s32x_sdram_resp
// Revision: 1.0
// ============================================================================
module tb_s32x_sdram_resp;
    localparam logic [6:0] K_W   = 7'h01;
    localparam logic [6:0] K_R   = 7'h02;
    localparam logic [6:0] K_WE  = 7'h04;
    localparam logic [6:0] K_BE  = 7'h08;
    localparam logic [6:0] K_AD  = 7'h10;
    localparam logic [6:0] K_MD  = 7'h20;
    localparam logic [6:0] K_SD  = 7'h40;
    localparam logic [6:0] K_ALL = 7'h7F;
    localparam logic [6:0] K_MEM = 7'h3E;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [16:0] sdr_a = '0;
    logic [15:0] sdr_di = '0;
    logic        sdr_cs = 1'b0;
    logic [1:0]  sdr_we = 2'b00;
    logic        sdr_rd = 1'b0;
    logic [15:0] mem_di = '0;
    logic        mem_ack = 1'b0;

    logic [15:0] do0, mdo0, do1, mdo1;
    logic        wait0, mwe0, req0, wait1, mwe1, req1;
    logic [16:0] addr0, addr1;
    logic [1:0]  be0, be1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    s32x_sdram_resp #(.POST_WRITES(1), .ADDR_W(17)) dut_post (
        .CLK(CLK), .RST_N(RST_N), .SDR_A(sdr_a), .SDR_DI(sdr_di), .SDR_DO(do0),
        .SDR_CS(sdr_cs), .SDR_WE(sdr_we), .SDR_RD(sdr_rd), .SDR_WAIT(wait0),
        .MEM_ADDR(addr0), .MEM_DO(mdo0), .MEM_BE(be0), .MEM_WE(mwe0),
        .MEM_REQ(req0), .MEM_DI(mem_di), .MEM_ACK(mem_ack)
    );

    s32x_sdram_resp #(.POST_WRITES(0), .ADDR_W(17)) dut_nopost (
        .CLK(CLK), .RST_N(RST_N), .SDR_A(sdr_a), .SDR_DI(sdr_di), .SDR_DO(do1),
        .SDR_CS(sdr_cs), .SDR_WE(sdr_we), .SDR_RD(sdr_rd), .SDR_WAIT(wait1),
        .MEM_ADDR(addr1), .MEM_DO(mdo1), .MEM_BE(be1), .MEM_WE(mwe1),
        .MEM_REQ(req1), .MEM_DI(mem_di), .MEM_ACK(mem_ack)
    );

    typedef struct {
        string       name;
        bit          dut;
        logic        rst_n;
        logic        cs;
        logic        rd;
        logic [1:0]  we;
        logic [16:0] a;
        logic [15:0] di;
        logic        ack;
        logic [15:0] mdi;
        logic [6:0]  chk;
        logic        e_wait;
        logic        e_req;
        logic        e_mwe;
        logic [1:0]  e_be;
        logic [16:0] e_addr;
        logic [15:0] e_mdo;
        logic [15:0] e_do;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, bit d, logic r, logic cs, logic rd, logic [1:0] we,
                                logic [16:0] a, logic [15:0] di, logic ack, logic [15:0] mdi,
                                logic [6:0] chk, logic w, logic rq, logic mwe, logic [1:0] be,
                                logic [16:0] ad, logic [15:0] mdo, logic [15:0] sdo);
        vec_t v;
        v.name = n; v.dut = d; v.rst_n = r; v.cs = cs; v.rd = rd; v.we = we; v.a = a;
        v.di = di; v.ack = ack; v.mdi = mdi; v.chk = chk; v.e_wait = w; v.e_req = rq;
        v.e_mwe = mwe; v.e_be = be; v.e_addr = ad; v.e_mdo = mdo; v.e_do = sdo;
        vecs.push_back(v);
    endfunction

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge CLK);
        RST_N = v.rst_n; sdr_cs = v.cs; sdr_rd = v.rd; sdr_we = v.we;
        sdr_a = v.a; sdr_di = v.di; mem_ack = v.ack; mem_di = v.mdi;
        #1;
        if (v.chk[0]) check({v.name, ".wait"}, v.dut ? 32'(wait1) : 32'(wait0), 32'(v.e_wait));
        if (v.chk[1]) check({v.name, ".req"},  v.dut ? 32'(req1)  : 32'(req0),  32'(v.e_req));
        if (v.chk[2]) check({v.name, ".mwe"},  v.dut ? 32'(mwe1)  : 32'(mwe0),  32'(v.e_mwe));
        if (v.chk[3]) check({v.name, ".be"},   v.dut ? 32'(be1)   : 32'(be0),   32'(v.e_be));
        if (v.chk[4]) check({v.name, ".addr"}, v.dut ? 32'(addr1) : 32'(addr0), 32'(v.e_addr));
        if (v.chk[5]) check({v.name, ".mdo"},  v.dut ? 32'(mdo1)  : 32'(mdo0),  32'(v.e_mdo));
        if (v.chk[6]) check({v.name, ".sdo"},  v.dut ? 32'(do1)   : 32'(do0),   32'(v.e_do));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0; sdr_cs = 1'b0; sdr_rd = 1'b0; sdr_we = 2'b00; mem_ack = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    initial begin
        int reqcyc;
        int waitcnt;
        bit got;

        // name dut rst cs rd we a di ack mdi | chk wait req mwe be addr mdo sdo
        add("rst_apply", 0, 0, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, 7'h00, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("rst_state", 0, 0, 1, 1, 2'b00, 17'h5, 16'h0, 0, 16'h0, K_ALL, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("idle",      0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_W|K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        // Posted write
        add("pw_strobe", 0, 1, 1, 0, 2'b10, 17'h00020, 16'h12AB, 0, 16'h0, K_W|K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("pw_req",    0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_W|K_MEM, 0, 1, 1, 2'b10, 17'h00020, 16'h12AB, 16'h0);
        add("pw_ack",    0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 1, 16'h0, K_W|K_R, 0, 1, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("pw_done",   0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        // Write then read of the same address under continuous CS
        add("wr_post",   0, 1, 1, 0, 2'b01, 17'h00040, 16'h5566, 0, 16'h0, K_W|K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("wr_rdwait", 0, 1, 1, 1, 2'b00, 17'h00040, 16'h0, 0, 16'h0, K_W|K_MEM, 1, 1, 1, 2'b01, 17'h00040, 16'h5566, 16'h0);
        add("wr_drack",  0, 1, 1, 1, 2'b00, 17'h00040, 16'h0, 1, 16'h0, K_W|K_R, 1, 1, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("wr_gap",    0, 1, 1, 1, 2'b00, 17'h00040, 16'h0, 0, 16'h0, K_W|K_R, 1, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("wr_rdreq",  0, 1, 1, 1, 2'b00, 17'h00040, 16'h0, 0, 16'h0, K_W|K_R|K_WE|K_BE|K_AD, 1, 1, 0, 2'b11, 17'h00040, 16'h0, 16'h0);
        add("wr_rdack",  0, 1, 1, 1, 2'b00, 17'h00040, 16'h0, 1, 16'h7788, K_W|K_R, 0, 1, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("wr_rdhold", 0, 1, 1, 1, 2'b00, 17'h00040, 16'h0, 0, 16'h0, K_W|K_R|K_SD, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h7788);
        add("wr_rdend",  0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_W|K_SD, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h7788);
        // Second write arrives during the first write's drain
        add("ww_post1",  0, 1, 1, 0, 2'b11, 17'h00100, 16'hAAAA, 0, 16'h0, K_W|K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("ww_wait1",  0, 1, 1, 0, 2'b11, 17'h00101, 16'hBBBB, 0, 16'h0, K_W|K_MEM, 1, 1, 1, 2'b11, 17'h00100, 16'hAAAA, 16'h0);
        add("ww_wait2",  0, 1, 1, 0, 2'b11, 17'h00101, 16'hBBBB, 0, 16'h0, K_W|K_R|K_AD, 1, 1, 0, 2'b00, 17'h00100, 16'h0, 16'h0);
        add("ww_drack",  0, 1, 1, 0, 2'b11, 17'h00101, 16'hBBBB, 1, 16'h0, K_W|K_R, 1, 1, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("ww_post2",  0, 1, 1, 0, 2'b11, 17'h00101, 16'hBBBB, 0, 16'h0, K_W|K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("ww_req2",   0, 1, 1, 0, 2'b11, 17'h00101, 16'hBBBB, 0, 16'h0, K_W|K_MEM|K_SD, 0, 1, 1, 2'b11, 17'h00101, 16'hBBBB, 16'h7788);
        add("ww_ack2",   0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 1, 16'h0, K_R, 0, 1, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("ww_idle",   0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        // Stray ACK in IDLE
        add("stray_ack", 0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 1, 16'h1111, K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("stray_chk", 0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_R|K_SD, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h7788);
        // Read abandoned while outstanding: bus completes, data discarded
        add("ab_strobe", 0, 1, 1, 1, 2'b00, 17'h00055, 16'h0, 0, 16'h0, K_W|K_R, 1, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("ab_drop",   0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_W|K_R|K_WE|K_AD, 0, 1, 0, 2'b00, 17'h00055, 16'h0, 16'h0);
        add("ab_ack",    0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 1, 16'h9999, K_R, 0, 1, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("ab_after",  0, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_R|K_SD, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h7788);
        // Non-posted write, ACK two cycles after REQ rises
        add("np_rst",    1, 0, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, 7'h00, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("np_idle",   1, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_W|K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("np_strobe", 1, 1, 1, 0, 2'b10, 17'h00030, 16'h4321, 0, 16'h0, K_W|K_R, 1, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("np_req",    1, 1, 1, 0, 2'b10, 17'h00030, 16'h4321, 0, 16'h0, K_W|K_MEM, 1, 1, 1, 2'b10, 17'h00030, 16'h4321, 16'h0);
        add("np_wait",   1, 1, 1, 0, 2'b10, 17'h00030, 16'h4321, 0, 16'h0, K_W|K_R, 1, 1, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("np_ack",    1, 1, 1, 0, 2'b10, 17'h00030, 16'h4321, 1, 16'h0, K_W|K_R, 0, 1, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("np_hold",   1, 1, 1, 0, 2'b10, 17'h00030, 16'h4321, 0, 16'h0, K_W|K_R, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);
        add("np_end",    1, 1, 0, 0, 2'b00, 17'h0, 16'h0, 0, 16'h0, K_W, 0, 0, 0, 2'b00, 17'h0, 16'h0, 16'h0);

        foreach (vecs[i]) apply(vecs[i]);

        // Read with memory holding REQ three cycles before ACK
        do_reset();
        @(negedge CLK);
        sdr_cs = 1'b1; sdr_rd = 1'b1; sdr_we = 2'b00; sdr_a = 17'h00010; mem_di = 16'hBEEF;
        reqcyc = 0; waitcnt = 0; got = 1'b0;
        for (int c = 0; c < 16 && !got; c++) begin
            if (c != 0) @(negedge CLK);
            if (req0) reqcyc++;
            mem_ack = (reqcyc == 4);
            #1;
            if (wait0) waitcnt++;
            if (mem_ack) got = 1'b1;
        end
        check("rd3.ack_seen", 32'(got), 32'd1);
        check("rd3.wait_cycles", 32'(waitcnt), 32'd4);
        @(negedge CLK);
        mem_ack = 1'b0; mem_di = 16'h0000;
        #1;
        check("rd3.data", 32'(do0), 32'hBEEF);
        check("rd3.wait_after", 32'(wait0), 32'd0);
        for (int k = 0; k < 2; k++) begin
            @(negedge CLK);
            #1;
            check("rd3.hold", 32'(do0), 32'hBEEF);
            check("rd3.req_low", 32'(req0), 32'd0);
        end

        // Reset asserted mid-read, stale ACK afterwards
        do_reset();
        @(negedge CLK);
        sdr_cs = 1'b1; sdr_rd = 1'b1; sdr_a = 17'h01234; mem_ack = 1'b0;
        #1;
        check("rstrd.wait", 32'(wait0), 32'd1);
        @(negedge CLK);
        #1;
        check("rstrd.req", 32'(req0), 32'd1);
        RST_N = 1'b0;
        #1;
        check("rstrd.wait_forced", 32'(wait0), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1; sdr_cs = 1'b0; sdr_rd = 1'b0; mem_ack = 1'b1; mem_di = 16'hDEAD;
        #1;
        check("rstrd.req_cleared", 32'(req0), 32'd0);
        check("rstrd.do_cleared", 32'(do0), 32'd0);
        check("rstrd.wait_low", 32'(wait0), 32'd0);
        @(negedge CLK);
        mem_ack = 1'b0;
        #1;
        check("rstrd.stale_req", 32'(req0), 32'd0);
        check("rstrd.stale_do", 32'(do0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/s32x_sdram_resp.md
Name: s32x_sdram_resp

Overview:
- Responder for the 32X SH2 SDRAM bus (CS3 region, 256 KB, 16-bit). It sits between the SDR_* port of the 32X core and a generic handshaked memory controller port.
- Decodes SH2 read/write strobes and drives SDR_WAIT to stall the SH2s until data is valid.
- Posts single writes through a one-entry write buffer and returns read data held stable until the access ends.

Parameters:
- POST_WRITES, 1, 1 = writes complete with zero wait when the buffer is free; 0 = every write waits for MEM_ACK.
- ADDR_W, 17, word-address width of SDR_A and MEM_ADDR.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  synchronous active-low reset
- SDR_A  in  ADDR_W  SH2 word address (bits 17:1)
- SDR_DI  in  16  write data from SH2
- SDR_DO  out  16  read data to SH2
- SDR_CS  in  1  SDRAM region select, active high
- SDR_WE  in  2  byte write enables, [1]=upper, [0]=lower, active high
- SDR_RD  in  1  read strobe, active high
- SDR_WAIT  out  1  stall to SH2, active high
- MEM_ADDR  out  ADDR_W  memory word address
- MEM_DO  out  16  memory write data
- MEM_BE  out  2  memory byte enables
- MEM_WE  out  1  1 = write, 0 = read
- MEM_REQ  out  1  request level, held until ACK
- MEM_DI  in  16  memory read data, valid with MEM_ACK
- MEM_ACK  in  1  one-cycle completion pulse

Behaviour:
- Reset (RST_N=0 at a CLK edge) clears all state; the reset takes effect even mid-transaction:
  - state=IDLE, write buffer empty, served=0.
  - SDR_DO=0, MEM_REQ=0, MEM_WE=0, MEM_BE=0, MEM_ADDR=0, MEM_DO=0.
  - SDR_WAIT is forced 0 while RST_N=0.
  - A MEM_ACK arriving after reset is ignored.
- Access present: ACC = SDR_CS & (SDR_RD | SDR_WE!=0).
- New access: ACC & ~served. The registered served flag is set when the access completes. It clears when:
  - ACC drops, or
  - SDR_A, SDR_RD or SDR_WE differ from the values latched at completion. Back-to-back accesses under a continuous CS are therefore distinguished.
- SDR_WAIT is combinational: SDR_WAIT = new access & ~done_now. It asserts in the same cycle the strobe appears.
  - done_now (read) = state RD_WAIT & MEM_ACK.
  - done_now (write) = buffer free this cycle (posted mode), or state WR_WAIT & MEM_ACK.
- States: IDLE, DRAIN, RD_WAIT, WR_WAIT. MEM_REQ=1 in DRAIN, RD_WAIT and WR_WAIT. The MEM_* outputs are registered and stable while MEM_REQ=1.
- IDLE:
  - Buffer full → DRAIN, presenting the buffered address/data/BE with MEM_WE=1. Draining has priority over any pending read or write.
  - Else new read → RD_WAIT: MEM_ADDR=SDR_A, MEM_WE=0, MEM_BE=2'b11.
  - Else new write with POST_WRITES=1:
    - Latch SDR_A, SDR_DI and SDR_WE into the buffer.
    - Set served, and WAIT=0 that cycle.
    - Next state is DRAIN.
  - Else new write with POST_WRITES=0 → WR_WAIT.
- DRAIN + MEM_ACK → buffer empty, MEM_REQ=0 → IDLE. The next request is issued no earlier than the following cycle, so MEM_REQ shows at least one low cycle between transactions.
- RD_WAIT + MEM_ACK:
  - SDR_DO <= MEM_DI, served=1 → IDLE.
  - SDR_DO holds that value until the next read completes.
  - Minimum read latency is 2 CLK from the strobe: request cycle, then ACK cycle.
- WR_WAIT + MEM_ACK → served=1 → IDLE.
- Read hitting the buffered address: the buffer drains first, then the read is issued. No forwarding is done, so the read returns the new data.
- Write with the buffer full: WAIT=1 until the drain ACK, then the write is posted in IDLE.
- ACC dropping while a request is outstanding (abnormal): the memory transaction still completes. The result is discarded for reads and kept for writes, and served is not set.
- MEM_ACK outside DRAIN/RD_WAIT/WR_WAIT is ignored.
- Byte writes: MEM_BE = latched SDR_WE. Unselected bytes of MEM_DO equal SDR_DI unchanged.

Test Plan:
- Reset mid-read:
  - Stimulus: RD to 0x01234, RST_N low the cycle after MEM_REQ rises, stale ACK delivered after reset.
  - Required: MEM_REQ=0, SDR_WAIT=0, SDR_DO=0; the stale ACK has no effect.
- Read with 3-cycle memory latency:
  - Stimulus: RD to 0x00010, MEM_DI=0xBEEF.
  - Required: SDR_WAIT=1 for exactly 4 cycles; SDR_DO=0xBEEF the cycle after ACK and held while CS stays high.
- Posted write:
  - Stimulus: WE=2'b10, A=0x00020, DI=0x12AB.
  - Required: SDR_WAIT never asserts; next cycle MEM_REQ=1, MEM_WE=1, MEM_BE=2'b10, MEM_ADDR=0x00020, MEM_DO=0x12AB.
- Write then immediate read of the same address, CS continuous:
  - Required: the read waits through the drain; MEM_REQ has a low cycle between transactions; the second request is a read; SDR_DO equals the memory-returned value.
- Two consecutive writes with the second arriving during drain:
  - Required: the second write sees WAIT=1 until the drain ACK, then completes with zero further wait; the memory sees the writes in order.
- POST_WRITES=0:
  - Stimulus: write with 2-cycle ACK latency.
  - Required: SDR_WAIT=1 until the ACK cycle, deasserting in that cycle.
